// File: rtl/combo_lock_ctrl.sv
// Combination-lock controller feeding a 4-digit seven-segment driver.
// Collects four hex key presses, compares them against CODE, and manages
// the LOCKED / CHECK / UNLOCKED / LOCKOUT states. A counter tracks
// consecutive failed attempts, and a timer holds the LOCKOUT state.
module combo_lock_ctrl #(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_val,
  input  logic       clear,
  input  logic       lock_cmd,
  output logic [3:0] disp3,
  output logic [3:0] disp2,
  output logic [3:0] disp1,
  output logic [3:0] disp0,
  output logic       unlocked,
  output logic       lockout,
  output logic       err_pulse
);

  localparam int             FW     = $clog2(MAX_TRIES + 1);
  localparam logic [FW-1:0]  MAX_T  = FW'(MAX_TRIES);
  localparam logic [23:0]    T_LOAD = 24'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_CHECK    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  state_t        r_state, w_state_next;
  logic [15:0]   r_entry, w_entry_next;
  logic [1:0]    r_count, w_count_next;
  logic [FW-1:0] r_fail, w_fail_next;
  logic [23:0]   r_timer, w_timer_next;
  logic [15:0]   r_disp, w_disp_next;
  logic          r_unlocked, r_lockout, r_err, w_err_next;
  logic [FW-1:0] w_fail_inc;

  assign w_fail_inc = r_fail + FW'(1);

  // Next-state logic: entry shifting, code check, fail counting and lockout timing.
  always_comb begin
    w_state_next = r_state;
    w_entry_next = r_entry;
    w_count_next = r_count;
    w_fail_next  = r_fail;
    w_timer_next = r_timer;
    w_err_next   = 1'b0;
    case (r_state)
      ST_LOCKED: begin
        // clear wins over a key arriving in the same cycle
        if (clear) begin
          w_entry_next = 16'h0000;
          w_count_next = 2'd0;
        end else if (key_valid) begin
          w_entry_next = {r_entry[11:0], key_val};
          if (r_count == 2'd3) begin
            w_count_next = 2'd0;
            w_state_next = ST_CHECK;
          end else begin
            w_count_next = r_count + 2'd1;
          end
        end
      end
      ST_CHECK: begin
        w_entry_next = 16'h0000;
        w_count_next = 2'd0;
        if (r_entry == CODE) begin
          w_state_next = ST_UNLOCKED;
          w_fail_next  = '0;
        end else begin
          w_err_next  = 1'b1;
          w_fail_next = w_fail_inc;
          if (w_fail_inc == MAX_T) begin
            w_state_next = ST_LOCKOUT;
            w_timer_next = T_LOAD;
          end else begin
            w_state_next = ST_LOCKED;
          end
        end
      end
      ST_UNLOCKED: begin
        if (lock_cmd) begin
          w_state_next = ST_LOCKED;
          w_entry_next = 16'h0000;
          w_count_next = 2'd0;
        end
      end
      ST_LOCKOUT: begin
        // timer runs from LOCKOUT_CYCLES-1 down to 0, one state cycle per value
        if (r_timer == 24'd0) begin
          w_state_next = ST_LOCKED;
          w_fail_next  = '0;
        end else begin
          w_timer_next = r_timer - 24'd1;
        end
      end
      default: begin
        w_state_next = ST_LOCKED;
      end
    endcase
  end

  // Display content follows the state being entered so it updates with it.
  always_comb begin
    w_disp_next = w_entry_next;
    case (w_state_next)
      ST_UNLOCKED: w_disp_next = 16'hAAAA;
      ST_LOCKOUT:  w_disp_next = 16'hEEEE;
      default:     w_disp_next = w_entry_next;
    endcase
  end

  // State, datapath and registered outputs, all cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_LOCKED;
      r_entry    <= 16'h0000;
      r_count    <= 2'd0;
      r_fail     <= '0;
      r_timer    <= 24'd0;
      r_disp     <= 16'h0000;
      r_unlocked <= 1'b0;
      r_lockout  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_entry    <= w_entry_next;
      r_count    <= w_count_next;
      r_fail     <= w_fail_next;
      r_timer    <= w_timer_next;
      r_disp     <= w_disp_next;
      r_unlocked <= (w_state_next == ST_UNLOCKED);
      r_lockout  <= (w_state_next == ST_LOCKOUT);
      r_err      <= w_err_next;
    end
  end

  assign disp3     = r_disp[15:12];
  assign disp2     = r_disp[11:8];
  assign disp1     = r_disp[7:4];
  assign disp0     = r_disp[3:0];
  assign unlocked  = r_unlocked;
  assign lockout   = r_lockout;
  assign err_pulse = r_err;

endmodule

// File: doc/combo_lock_ctrl.md
Name: combo_lock_ctrl

Overview:
- Combination-lock controller that sits directly upstream of the 4-digit seven-segment driver.
- Accepts debounced hex key presses, shifts them into a 4-digit entry register and compares the entry against a parameterised code.
- Manages the locked, unlocked and lockout states, with a failed-attempt counter and a timed lockout.
- Drives the four 4-bit display digits, which are always in the range 0..F, plus status flags.

Parameters:
CODE, 16'h1234, unlock code; [15:12] is the first digit entered, [3:0] the last.
MAX_TRIES, 3, consecutive wrong codes that trigger lockout (legal range 1..15).
LOCKOUT_CYCLES, 16, clk cycles spent in LOCKOUT (legal range 2..2^24; 16 for simulation, roughly 10^8 for hardware).

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
key_valid  in  1  one-cycle pulse; key_val is valid on that cycle (already debounced and edge-detected upstream).
key_val  in  4  hex digit pressed.
clear  in  1  one-cycle pulse; discards the partial entry.
lock_cmd  in  1  one-cycle pulse; relocks from UNLOCKED.
disp3  out  4  leftmost display digit.
disp2  out  4  display digit.
disp1  out  4  display digit.
disp0  out  4  rightmost display digit.
unlocked  out  1  high while in UNLOCKED.
lockout  out  1  high while in LOCKOUT.
err_pulse  out  1  one-cycle pulse on each wrong code.

Behaviour:
- All state is in flops, cleared by asynchronous rst.
- Reset values:
  - state = LOCKED
  - entry register = 16'h0000; entry count = 0
  - fail count = 0; lockout timer = 0
  - disp3..disp0 = 0
  - unlocked = 0, lockout = 0, err_pulse = 0
- States: LOCKED, CHECK, UNLOCKED, LOCKOUT.
- LOCKED:
  - On key_valid, the entry shifts left one digit: entry <= {entry[11:0], key_val}; count increments.
  - When key_valid arrives with count == 3, the 4th digit is shifted in, count returns to 0 and next state = CHECK.
  - clear has priority over key_valid in the same cycle: entry = 0 and count = 0, the key is dropped.
  - lock_cmd is ignored.
- CHECK (exactly one cycle; all inputs ignored):
  - entry == CODE: next state UNLOCKED; fail count = 0.
  - Mismatch: err_pulse = 1 on the next cycle and fail count increments.
    - If the new count == MAX_TRIES: next state LOCKOUT; timer loaded with LOCKOUT_CYCLES-1.
    - Otherwise: next state LOCKED.
  - The entry register is cleared on leaving CHECK on either path.
- UNLOCKED:
  - key_valid and clear are ignored.
  - lock_cmd: next state LOCKED, entry = 0, count = 0.
- LOCKOUT:
  - key_valid, clear and lock_cmd are all ignored.
  - The timer decrements every cycle.
  - When timer == 0: next state LOCKED and fail count = 0.
  - Total time in LOCKOUT is exactly LOCKOUT_CYCLES cycles.
- Latency: if the 4th key is sampled at edge E, state is CHECK after E and UNLOCKED/LOCKED/LOCKOUT after E+1. unlocked, lockout and err_pulse change with that same edge E+1.
- Display outputs (registered, updated on the same edge as the state and entry):
  - LOCKED and CHECK: disp3..disp0 = entry[15:12], [11:8], [7:4], [3:0].
  - UNLOCKED: all four digits = 4'hA.
  - LOCKOUT: all four digits = 4'hE.
- Status outputs:
  - unlocked = (state == UNLOCKED), registered.
  - lockout = (state == LOCKOUT), registered.
- Fail count:
  - Width $clog2(MAX_TRIES+1); it never exceeds MAX_TRIES.
  - It persists across LOCKED, survives clear, and is cleared only by a correct code, lockout expiry or rst.
- Timer width is 24 bits. The lockout timer never underflows.
- rst mid-entry or mid-lockout returns immediately to the reset values; no partial state is retained.

Test Plan:
- Reset, then keys 1,2,3,4 -> disp shows 0001, 0012, 0123, 1234 after each key; unlocked=1 two edges after the 4th key, disp=AAAA, err_pulse never pulses.
- Keys 1,2,3,5 -> err_pulse high for exactly 1 cycle; unlocked=0; disp=0000 afterwards; fail count=1.
- Three wrong codes -> lockout=1, disp=EEEE for exactly 16 cycles; keys during lockout are ignored; then LOCKED with disp=0000. Entering 1,2,3,4 after expiry unlocks (fail count was reset).
- Keys 1,2, then clear and key_valid(7) on the same cycle -> disp=0000, count=0; then 1,2,3,4 -> unlocked.
- In UNLOCKED, keys and clear are ignored and disp stays AAAA; lock_cmd -> LOCKED next cycle, disp=0000, unlocked=0.
- Assert rst asynchronously during the 3rd key and again mid-lockout -> all outputs at reset values immediately; fail count=0 verified by needing 3 more wrong codes to reach lockout.
